rw_stage: RTL and testbench



---
 rtl/rw_stage.sv | 144 ++++++++++++++
 tb/tb_rw_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rw_stage.sv
// Register-writeback stage: buffers memory-stage results in a small FIFO and
// drives the single GPR write port, counting retired instructions until a halt retires.
module rw_stage #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Ma_Valid_i,
   output logic             Ma_Ready_o,
   input  logic [31:0]      Ma_Pc_i,
   input  logic [3:0]       Ma_Rd_i,
   input  logic [31:0]      Ma_AluRes_i,
   input  logic [31:0]      Ma_LdRes_i,
   input  logic             Ma_IsLd_i,
   input  logic             Ma_IsCall_i,
   input  logic             Ma_IsWb_i,
   input  logic             Ma_IsHalt_i,
   input  logic             Gpr_Wr_Ready_i,
   output logic             Wr_En_o,
   output logic [3:0]       Wr_Addr_o,
   output logic [31:0]      Wr_Data_o,
   output logic [CNT_W-1:0] Retired_Cnt_o,
   output logic             Halted_o
);

   // state   | meaning
   // RUN     | accepting and retiring entries
   // HALTED  | a halt has retired; stage frozen until Rst
   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   localparam int        AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   state_t             r_state;
   state_t             w_state_nxt;

   logic [31:0]        r_data [DEPTH];
   logic [3:0]         r_addr [DEPTH];
   logic [DEPTH-1:0]   r_wb;
   logic [DEPTH-1:0]   r_halt;
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [AW:0]        r_count;
   logic               r_halt_seen;
   logic [CNT_W-1:0]   r_retired;

   logic               w_full;
   logic               w_head_valid;
   logic               w_head_wb;
   logic               w_head_halt;
   logic               w_ready;
   logic               w_push;
   logic               w_pop;
   logic [31:0]        w_ent_data;
   logic [3:0]         w_ent_addr;
   logic               w_ent_wb;

   // Entry formation: call > load > ALU; calls link into r15.
   always_comb begin
      w_ent_data = Ma_AluRes_i;
      if (Ma_IsCall_i)
         w_ent_data = Ma_Pc_i + 32'd4;
      else if (Ma_IsLd_i)
         w_ent_data = Ma_LdRes_i;
   end

   assign w_ent_addr   = Ma_IsCall_i ? 4'hF : Ma_Rd_i;
   assign w_ent_wb     = (Ma_IsWb_i | Ma_IsCall_i) & ~Ma_IsHalt_i;

   assign w_full       = (r_count == FULL_CNT);
   assign w_head_valid = (r_count != '0) && (r_state == ST_RUN);
   assign w_head_wb    = r_wb[r_rd_ptr];
   assign w_head_halt  = r_halt[r_rd_ptr];

   // Ready comes only from registered state, never from the write port.
   assign w_ready      = ~w_full & ~r_halt_seen & (r_state == ST_RUN);
   assign w_push       = Ma_Valid_i & w_ready;
   assign w_pop        = w_head_valid & (~w_head_wb | Gpr_Wr_Ready_i);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:    if (w_pop && w_head_halt) w_state_nxt = ST_HALTED;
         ST_HALTED: w_state_nxt = ST_HALTED;
         default:   w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst)
         r_state <= ST_RUN;
      else
         r_state <= w_state_nxt;
   end

   // Payload storage needs no reset; validity is carried by the pointers.
   always_ff @(posedge Clk) begin
      if (w_push) begin
         r_data[r_wr_ptr] <= w_ent_data;
         r_addr[r_wr_ptr] <= w_ent_addr;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_wb        <= '0;
         r_halt      <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_halt_seen <= 1'b0;
         r_retired   <= '0;
      end else begin
         if (w_push) begin
            r_wb[r_wr_ptr]   <= w_ent_wb;
            r_halt[r_wr_ptr] <= Ma_IsHalt_i;
            r_wr_ptr         <= r_wr_ptr + AW'(1);
            if (Ma_IsHalt_i)
               r_halt_seen <= 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + AW'(1);
            r_retired <= r_retired + CNT_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign Ma_Ready_o    = w_ready;
   assign Wr_En_o       = w_head_valid & w_head_wb;
   assign Wr_Addr_o     = w_head_valid ? r_addr[r_rd_ptr] : 4'h0;
   assign Wr_Data_o     = w_head_valid ? r_data[r_rd_ptr] : 32'h0;
   assign Retired_Cnt_o = r_retired;
   assign Halted_o      = (r_state == ST_HALTED);

endmodule

// File: tb/tb_rw_stage.sv
// Bench for rw_stage: directed test-plan sequences plus random traffic, checked
// against a queue-based model of the stage's buffered results.
module tb_rw_stage;

   localparam int DEPTH = 2;
   localparam int CNT_W = 32;

   logic             Clk = 1'b0;
   logic             Rst = 1'b1;
   logic             v = 1'b0;
   logic [31:0]      pc = '0;
   logic [3:0]       rd = '0;
   logic [31:0]      alu = '0;
   logic [31:0]      ld = '0;
   logic             isld = 1'b0;
   logic             iscall = 1'b0;
   logic             iswb = 1'b0;
   logic             ishalt = 1'b0;
   logic             gpr_rdy = 1'b1;

   logic             ma_ready;
   logic             wr_en;
   logic [3:0]       wr_addr;
   logic [31:0]      wr_data;
   logic [CNT_W-1:0] retired;
   logic             halted;

   rw_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .Clk           (Clk),
      .Rst           (Rst),
      .Ma_Valid_i    (v),
      .Ma_Ready_o    (ma_ready),
      .Ma_Pc_i       (pc),
      .Ma_Rd_i       (rd),
      .Ma_AluRes_i   (alu),
      .Ma_LdRes_i    (ld),
      .Ma_IsLd_i     (isld),
      .Ma_IsCall_i   (iscall),
      .Ma_IsWb_i     (iswb),
      .Ma_IsHalt_i   (ishalt),
      .Gpr_Wr_Ready_i(gpr_rdy),
      .Wr_En_o       (wr_en),
      .Wr_Addr_o     (wr_addr),
      .Wr_Data_o     (wr_data),
      .Retired_Cnt_o (retired),
      .Halted_o      (halted)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [3:0]  addr;
      logic [31:0] data;
      logic        wb;
      logic        halt;
   } ent_t;

   ent_t        sb[$];
   logic        m_hs = 1'b0;
   logic        m_halted = 1'b0;
   logic [31:0] m_cnt = '0;
   int          n_chk = 0;
   int          n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Monitor/scoreboard: compare outputs mid-cycle, then advance the model to
   // what the coming clock edge should do with the current inputs.
   initial begin
      logic        exp_ready, exp_en, acc, pop;
      logic [3:0]  exp_addr;
      logic [31:0] exp_data;
      ent_t        e;
      forever begin
         @(negedge Clk);
         exp_ready = (sb.size() < DEPTH) && !m_hs && !m_halted;
         exp_en    = (sb.size() > 0) && sb[0].wb;
         exp_addr  = (sb.size() > 0) ? sb[0].addr : 4'h0;
         exp_data  = (sb.size() > 0) ? sb[0].data : 32'h0;
         chk("ready",   32'(ma_ready), 32'(exp_ready));
         chk("wr_en",   32'(wr_en),    32'(exp_en));
         chk("wr_addr", 32'(wr_addr),  32'(exp_addr));
         chk("wr_data", wr_data,       exp_data);
         chk("halted",  32'(halted),   32'(m_halted));
         chk("retired", retired,       m_cnt);
         if (Rst) begin
            sb.delete();
            m_hs     = 1'b0;
            m_halted = 1'b0;
            m_cnt    = '0;
         end else begin
            acc = v && exp_ready;
            pop = (sb.size() > 0) && (!sb[0].wb || gpr_rdy);
            if (pop) begin
               if (sb[0].halt) m_halted = 1'b1;
               m_cnt = m_cnt + 1;
               void'(sb.pop_front());
            end
            if (acc) begin
               e.data = iscall ? pc + 32'd4 : (isld ? ld : alu);
               e.addr = iscall ? 4'hF : rd;
               e.wb   = (iswb || iscall) && !ishalt;
               e.halt = ishalt;
               sb.push_back(e);
               if (ishalt) m_hs = 1'b1;
            end
         end
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge Clk);
         #2;
      end
   endtask

   task automatic idle();
      v = 1'b0; isld = 1'b0; iscall = 1'b0; iswb = 1'b0; ishalt = 1'b0;
   endtask

   task automatic put(input logic [31:0] p, input logic [3:0] r, input logic [31:0] a,
                      input logic [31:0] l, input logic fl, input logic fc,
                      input logic fw, input logic fh);
      v = 1'b1; pc = p; rd = r; alu = a; ld = l;
      isld = fl; iscall = fc; iswb = fw; ishalt = fh;
   endtask

   initial begin
      cyc(2);
      Rst = 1'b0;
      cyc();

      // ALU writeback
      gpr_rdy = 1'b1;
      put(32'h0, 4'd3, 32'h1234_5678, 32'h0, 0, 0, 1, 0); cyc();
      idle(); cyc(3);

      // call, load, call+load
      put(32'h100, 4'd2, 32'hDEAD, 32'h0, 0, 1, 0, 0); cyc();
      put(32'h0, 4'd7, 32'h0, 32'hCAFE, 1, 0, 1, 0); cyc();
      put(32'h200, 4'd5, 32'h1, 32'hBEEF, 1, 1, 1, 0); cyc();
      put(32'hFFFF_FFFC, 4'd1, 32'h0, 32'h0, 0, 1, 0, 0); cyc();
      idle(); cyc(3);

      // back-pressure with three writes into a two-deep FIFO
      gpr_rdy = 1'b0;
      put(32'h0, 4'd1, 32'hA1, 32'h0, 0, 0, 1, 0); cyc();
      put(32'h0, 4'd2, 32'hA2, 32'h0, 0, 0, 1, 0); cyc();
      put(32'h0, 4'd3, 32'hA3, 32'h0, 0, 0, 1, 0); cyc(3);
      gpr_rdy = 1'b1; cyc(4);
      idle(); cyc(2);

      // non-writing store ahead of a write, port stalled
      gpr_rdy = 1'b0;
      put(32'h0, 4'd4, 32'h5707E, 32'h0, 0, 0, 0, 0); cyc();
      put(32'h0, 4'd6, 32'h66, 32'h0, 0, 0, 1, 0); cyc();
      idle(); cyc(3);
      gpr_rdy = 1'b1; cyc(3);

      // halt after a write, then keep offering payload
      Rst = 1'b1; cyc(); Rst = 1'b0;
      put(32'h0, 4'd8, 32'h88, 32'h0, 0, 0, 1, 0); cyc();
      put(32'h0, 4'd9, 32'h99, 32'h0, 0, 0, 1, 1); cyc();
      put(32'h0, 4'd10, 32'hAA, 32'h0, 0, 0, 1, 0); cyc(6);
      idle();

      // reset while full and stalled
      Rst = 1'b1; cyc(); Rst = 1'b0;
      gpr_rdy = 1'b0;
      put(32'h0, 4'd11, 32'hB1, 32'h0, 0, 0, 1, 0); cyc();
      put(32'h0, 4'd12, 32'hB2, 32'h0, 0, 0, 1, 0); cyc(2);
      idle();
      Rst = 1'b1; cyc(); Rst = 1'b0;
      gpr_rdy = 1'b1; cyc(4);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         v       = ($urandom_range(0, 3) != 0);
         pc      = $urandom;
         rd      = 4'($urandom_range(0, 15));
         alu     = $urandom;
         ld      = $urandom;
         isld    = 1'($urandom_range(0, 1));
         iscall  = ($urandom_range(0, 5) == 0);
         iswb    = ($urandom_range(0, 3) != 0);
         ishalt  = ($urandom_range(0, 39) == 0);
         gpr_rdy = ($urandom_range(0, 2) != 0);
         Rst     = ($urandom_range(0, 79) == 0);
         cyc();
      end

      Rst = 1'b0; idle(); gpr_rdy = 1'b1;
      cyc(3);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
